// File: rtl/stash_flush_router.sv
// stash_flush_router
//
// Store-and-forward packet steering block. Incoming AXI-Stream packets are
// optionally filtered on UDP protocol (beat0) and destination port (beat1),
// then written into a packet FIFO with a speculative write pointer. A packet
// becomes visible to the reader only once its tlast beat has been written.
// A rejected or overflowing packet is rolled back to the last commit point.
// Each committed packet is paired, in order, with a queued lookup decision.
// It is then either forwarded whole to one output channel or flushed.
//
// Ports
//   axis_aclk, axis_reset      clock, asynchronous active-high reset
//   s_axis_*                   input stream (s_axis_tready is 1 outside reset)
//   i_dec_valid/port/drop      lookup decision strobe, target channel, flush flag
//   o_dec_ready                decision FIFO not full (combinational)
//   m_axis_*                   NUM_PORTS output channels, channel k in slice k
//   o_fwd_cnt                  packets forwarded
//   o_drop_filt_cnt            packets rejected by the filter
//   o_drop_ovf_cnt             packets dropped because the packet FIFO was full
//   o_drop_dec_cnt             packets flushed by decision (drop or bad port)
module stash_flush_router #(
  parameter int          DATA_WIDTH     = 256,
  parameter int          TUSER_WIDTH    = 128,
  parameter int          NUM_PORTS      = 4,
  parameter int          SEL_WIDTH      = 3,
  parameter int          PKT_DEPTH_BITS = 9,
  parameter int          DEC_DEPTH_BITS = 4,
  parameter bit          FILTER_EN      = 1'b1,
  parameter logic [7:0]  UDP_PROTO      = 8'h11,
  parameter logic [15:0] DST_PORT       = 16'd4791
) (
  input  logic                                 axis_aclk,
  input  logic                                 axis_reset,
  input  logic [DATA_WIDTH-1:0]                s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]              s_axis_tkeep,
  input  logic [TUSER_WIDTH-1:0]               s_axis_tuser,
  input  logic                                 s_axis_tvalid,
  input  logic                                 s_axis_tlast,
  output logic                                 s_axis_tready,
  input  logic                                 i_dec_valid,
  input  logic [SEL_WIDTH-1:0]                 i_dec_port,
  input  logic                                 i_dec_drop,
  output logic                                 o_dec_ready,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [NUM_PORTS*(DATA_WIDTH/8)-1:0]  m_axis_tkeep,
  output logic [NUM_PORTS*TUSER_WIDTH-1:0]     m_axis_tuser,
  output logic [NUM_PORTS-1:0]                 m_axis_tlast,
  output logic [NUM_PORTS-1:0]                 m_axis_tvalid,
  input  logic [NUM_PORTS-1:0]                 m_axis_tready,
  output logic [31:0]                          o_fwd_cnt,
  output logic [31:0]                          o_drop_filt_cnt,
  output logic [31:0]                          o_drop_ovf_cnt,
  output logic [31:0]                          o_drop_dec_cnt
);

  localparam int KEEP_WIDTH  = DATA_WIDTH / 8;
  localparam int ENTRY_WIDTH = DATA_WIDTH + KEEP_WIDTH + TUSER_WIDTH + 1;
  localparam int PTR_WIDTH   = PKT_DEPTH_BITS + 1;
  localparam int DPTR_WIDTH  = DEC_DEPTH_BITS + 1;
  localparam int CNT_WIDTH   = PKT_DEPTH_BITS + 1;

  typedef enum logic [1:0] {BEAT0, BEAT1, BEATN} beat_e;
  typedef enum logic [1:0] {IDLE, FORWARD, FLUSH} egress_e;

  // Storage arrays (not reset: contents are meaningless until pointers move)
  logic [ENTRY_WIDTH-1:0] pkt_mem [2**PKT_DEPTH_BITS];
  logic [SEL_WIDTH:0]     dec_mem [2**DEC_DEPTH_BITS];

  logic                   tready_q;
  logic [PTR_WIDTH-1:0]   wp_spec_q, wp_spec_d;
  logic [PTR_WIDTH-1:0]   wp_commit_q, wp_commit_d;
  logic [PTR_WIDTH-1:0]   rp_q, rp_d;
  beat_e                  beat_idx_q, beat_idx_d;
  logic                   discard_q, discard_d;
  logic [CNT_WIDTH-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic [31:0]            filt_cnt_q, filt_cnt_d;
  logic [31:0]            ovf_cnt_q, ovf_cnt_d;
  logic [31:0]            fwd_cnt_q, fwd_cnt_d;
  logic [31:0]            dec_cnt_q, dec_cnt_d;
  logic [DPTR_WIDTH-1:0]  dec_wp_q, dec_wp_d;
  logic [DPTR_WIDTH-1:0]  dec_rp_q, dec_rp_d;
  egress_e                state_q, state_d;
  logic [SEL_WIDTH-1:0]   sel_q, sel_d;
  logic                   loaded_last_q, loaded_last_d;
  logic                   out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic [KEEP_WIDTH-1:0]  out_keep_q, out_keep_d;
  logic [TUSER_WIDTH-1:0] out_user_q, out_user_d;
  logic                   out_last_q, out_last_d;

  logic                   in_fire;
  logic                   pkt_full;
  logic                   filt_rej;
  logic                   pkt_wr_en;
  logic                   commit_inc;
  logic                   pkt_release;
  logic                   dec_full;
  logic                   dec_empty;
  logic                   dec_push;
  logic                   dec_pop;
  logic [SEL_WIDTH:0]     dec_rd;
  logic                   dec_rd_drop;
  logic [SEL_WIDTH-1:0]   dec_rd_port;
  logic                   dec_port_bad;
  logic [ENTRY_WIDTH-1:0] rd_entry;
  logic                   rd_last;
  logic                   sel_ready;

  assign s_axis_tready = tready_q;
  assign in_fire       = s_axis_tvalid && tready_q;

  // Full is measured against the speculative pointer so an in-flight packet
  // can never overrun data the reader has not consumed yet.
  assign pkt_full = (wp_spec_q[PKT_DEPTH_BITS] != rp_q[PKT_DEPTH_BITS]) &&
                    (wp_spec_q[PKT_DEPTH_BITS-1:0] == rp_q[PKT_DEPTH_BITS-1:0]);

  // A single-beat packet can never carry the port field, so it is rejected.
  assign filt_rej = FILTER_EN &&
                    (((beat_idx_q == BEAT0) &&
                      ((s_axis_tdata[191:184] != UDP_PROTO) || s_axis_tlast)) ||
                     ((beat_idx_q == BEAT1) && (s_axis_tdata[47:32] != DST_PORT)));

  // Ingress: speculative write, commit on tlast, rollback on reject/overflow
  always_comb begin
    wp_spec_d   = wp_spec_q;
    wp_commit_d = wp_commit_q;
    beat_idx_d  = beat_idx_q;
    discard_d   = discard_q;
    filt_cnt_d  = filt_cnt_q;
    ovf_cnt_d   = ovf_cnt_q;
    pkt_wr_en   = 1'b0;
    commit_inc  = 1'b0;
    if (in_fire) begin
      if (s_axis_tlast) begin
        beat_idx_d = BEAT0;
      end else if (beat_idx_q == BEAT0) begin
        beat_idx_d = BEAT1;
      end else begin
        beat_idx_d = BEATN;
      end
      if (discard_q) begin
        if (s_axis_tlast) begin
          discard_d = 1'b0;
        end
      end else if (filt_rej || pkt_full) begin
        wp_spec_d = wp_commit_q;
        discard_d = !s_axis_tlast;
        if (filt_rej) begin
          filt_cnt_d = filt_cnt_q + 32'd1;
        end else begin
          ovf_cnt_d = ovf_cnt_q + 32'd1;
        end
      end else begin
        pkt_wr_en = 1'b1;
        wp_spec_d = wp_spec_q + PTR_WIDTH'(1);
        if (s_axis_tlast) begin
          wp_commit_d = wp_spec_q + PTR_WIDTH'(1);
          commit_inc  = 1'b1;
        end
      end
    end
  end

  // Decision FIFO flags and head entry
  assign dec_full  = (dec_wp_q[DEC_DEPTH_BITS] != dec_rp_q[DEC_DEPTH_BITS]) &&
                     (dec_wp_q[DEC_DEPTH_BITS-1:0] == dec_rp_q[DEC_DEPTH_BITS-1:0]);
  assign dec_empty = (dec_wp_q == dec_rp_q);
  assign o_dec_ready = !dec_full;
  assign dec_push  = i_dec_valid && !dec_full;
  assign dec_rd       = dec_mem[dec_rp_q[DEC_DEPTH_BITS-1:0]];
  assign dec_rd_drop  = dec_rd[SEL_WIDTH];
  assign dec_rd_port  = dec_rd[SEL_WIDTH-1:0];
  assign dec_port_bad = 32'(dec_rd_port) >= NUM_PORTS;

  // Decision FIFO pointer update
  always_comb begin
    dec_wp_d = dec_wp_q;
    dec_rp_d = dec_rp_q;
    if (dec_push) begin
      dec_wp_d = dec_wp_q + DPTR_WIDTH'(1);
    end
    if (dec_pop) begin
      dec_rp_d = dec_rp_q + DPTR_WIDTH'(1);
    end
  end

  assign rd_entry = pkt_mem[rp_q[PKT_DEPTH_BITS-1:0]];
  assign rd_last  = rd_entry[ENTRY_WIDTH-1];

  // Ready of the currently selected channel (loop avoids an oversized index)
  always_comb begin
    sel_ready = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (sel_q == SEL_WIDTH'(k)) begin
        sel_ready = m_axis_tready[k];
      end
    end
  end

  // Egress FSM: pair a committed packet with a decision, then forward or flush
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    loaded_last_d = loaded_last_q;
    rp_d          = rp_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_keep_d    = out_keep_q;
    out_user_d    = out_user_q;
    out_last_d    = out_last_q;
    fwd_cnt_d     = fwd_cnt_q;
    dec_cnt_d     = dec_cnt_q;
    dec_pop       = 1'b0;
    pkt_release   = 1'b0;
    case (state_q)
      IDLE: begin
        if ((pkt_cnt_q != '0) && !dec_empty) begin
          dec_pop       = 1'b1;
          sel_d         = dec_rd_port;
          loaded_last_d = 1'b0;
          state_d       = (dec_rd_drop || dec_port_bad) ? FLUSH : FORWARD;
        end
      end
      FORWARD: begin
        if (out_valid_q && out_last_q && sel_ready) begin
          out_valid_d = 1'b0;
          pkt_release = 1'b1;
          fwd_cnt_d   = fwd_cnt_q + 32'd1;
          state_d     = IDLE;
        end else if ((!out_valid_q || sel_ready) && !loaded_last_q) begin
          out_valid_d   = 1'b1;
          out_data_d    = rd_entry[DATA_WIDTH-1:0];
          out_keep_d    = rd_entry[DATA_WIDTH +: KEEP_WIDTH];
          out_user_d    = rd_entry[DATA_WIDTH+KEEP_WIDTH +: TUSER_WIDTH];
          out_last_d    = rd_last;
          loaded_last_d = rd_last;
          rp_d          = rp_q + PTR_WIDTH'(1);
        end else if (out_valid_q && sel_ready) begin
          out_valid_d = 1'b0;
        end
      end
      FLUSH: begin
        rp_d = rp_q + PTR_WIDTH'(1);
        if (rd_last) begin
          pkt_release = 1'b1;
          dec_cnt_d   = dec_cnt_q + 32'd1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Committed packet count; a same-cycle commit and release cancel out
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (commit_inc && !pkt_release) begin
      pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
    end else if (!commit_inc && pkt_release) begin
      pkt_cnt_d = pkt_cnt_q - CNT_WIDTH'(1);
    end
  end

  // The single output register is steered onto the selected channel only
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tuser  = '0;
    m_axis_tlast  = '0;
    m_axis_tvalid = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (sel_q == SEL_WIDTH'(k)) begin
        m_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH]   = out_data_q;
        m_axis_tkeep[k*KEEP_WIDTH +: KEEP_WIDTH]   = out_keep_q;
        m_axis_tuser[k*TUSER_WIDTH +: TUSER_WIDTH] = out_user_q;
        m_axis_tlast[k]                            = out_last_q;
        m_axis_tvalid[k]                           = out_valid_q;
      end
    end
  end

  assign o_fwd_cnt       = fwd_cnt_q;
  assign o_drop_filt_cnt = filt_cnt_q;
  assign o_drop_ovf_cnt  = ovf_cnt_q;
  assign o_drop_dec_cnt  = dec_cnt_q;

  // State registers
  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      tready_q      <= 1'b0;
      wp_spec_q     <= '0;
      wp_commit_q   <= '0;
      rp_q          <= '0;
      beat_idx_q    <= BEAT0;
      discard_q     <= 1'b0;
      pkt_cnt_q     <= '0;
      filt_cnt_q    <= '0;
      ovf_cnt_q     <= '0;
      fwd_cnt_q     <= '0;
      dec_cnt_q     <= '0;
      dec_wp_q      <= '0;
      dec_rp_q      <= '0;
      state_q       <= IDLE;
      sel_q         <= '0;
      loaded_last_q <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_keep_q    <= '0;
      out_user_q    <= '0;
      out_last_q    <= 1'b0;
    end else begin
      tready_q      <= 1'b1;
      wp_spec_q     <= wp_spec_d;
      wp_commit_q   <= wp_commit_d;
      rp_q          <= rp_d;
      beat_idx_q    <= beat_idx_d;
      discard_q     <= discard_d;
      pkt_cnt_q     <= pkt_cnt_d;
      filt_cnt_q    <= filt_cnt_d;
      ovf_cnt_q     <= ovf_cnt_d;
      fwd_cnt_q     <= fwd_cnt_d;
      dec_cnt_q     <= dec_cnt_d;
      dec_wp_q      <= dec_wp_d;
      dec_rp_q      <= dec_rp_d;
      state_q       <= state_d;
      sel_q         <= sel_d;
      loaded_last_q <= loaded_last_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_keep_q    <= out_keep_d;
      out_user_q    <= out_user_d;
      out_last_q    <= out_last_d;
    end
  end

  // Array writes
  always_ff @(posedge axis_aclk) begin
    if (pkt_wr_en) begin
      pkt_mem[wp_spec_q[PKT_DEPTH_BITS-1:0]] <=
        {s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata};
    end
    if (dec_push) begin
      dec_mem[dec_wp_q[DEC_DEPTH_BITS-1:0]] <= {i_dec_drop, i_dec_port};
    end
  end

endmodule

// File: tb/tb_stash_flush_router.sv
// Testbench for stash_flush_router. Expected beats are queued as packets are
// driven (only for packets meant to be forwarded, tagged with their channel);
// a negedge monitor pops and compares every beat handshaked on any channel,
// and checks that a stalled beat is held unchanged.
module tb_stash_flush_router;

  localparam int DW = 256;
  localparam int UW = 128;
  localparam int NP = 4;
  localparam int SW = 3;
  localparam int KW = DW / 8;

  logic              clk;
  logic              rst;
  logic [DW-1:0]     sTdata;
  logic [KW-1:0]     sTkeep;
  logic [UW-1:0]     sTuser;
  logic              sTvalid;
  logic              sTlast;
  logic              sTready;
  logic              decValid;
  logic [SW-1:0]     decPort;
  logic              decDrop;
  logic              decReady;
  logic [NP*DW-1:0]  mTdata;
  logic [NP*KW-1:0]  mTkeep;
  logic [NP*UW-1:0]  mTuser;
  logic [NP-1:0]     mTlast;
  logic [NP-1:0]     mTvalid;
  logic [NP-1:0]     mTready;
  logic [31:0]       fwdCnt, filtCnt, ovfCnt, decCnt;

  logic [NP-1:0]     readyBase;
  logic              bpEnable;
  logic              bpBit;
  logic [3:0]        bpPattern;
  int                bpIdx;

  typedef struct {
    int            chan;
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } expBeat_t;

  expBeat_t expQ[$];
  expBeat_t popped;

  int assertCount = 0;
  int failCount   = 0;

  logic          stallPending;
  int            prevChan;
  logic [DW-1:0] prevData;
  logic [NP-1:0] prevValid;

  assign mTready = bpEnable ? {readyBase[3:2], bpBit, readyBase[0]} : readyBase;

  stash_flush_router #(
    .DATA_WIDTH(DW), .TUSER_WIDTH(UW), .NUM_PORTS(NP), .SEL_WIDTH(SW),
    .PKT_DEPTH_BITS(9), .DEC_DEPTH_BITS(4), .FILTER_EN(1'b1),
    .UDP_PROTO(8'h11), .DST_PORT(16'd4791)
  ) dut (
    .axis_aclk(clk), .axis_reset(rst),
    .s_axis_tdata(sTdata), .s_axis_tkeep(sTkeep), .s_axis_tuser(sTuser),
    .s_axis_tvalid(sTvalid), .s_axis_tlast(sTlast), .s_axis_tready(sTready),
    .i_dec_valid(decValid), .i_dec_port(decPort), .i_dec_drop(decDrop),
    .o_dec_ready(decReady),
    .m_axis_tdata(mTdata), .m_axis_tkeep(mTkeep), .m_axis_tuser(mTuser),
    .m_axis_tlast(mTlast), .m_axis_tvalid(mTvalid), .m_axis_tready(mTready),
    .o_fwd_cnt(fwdCnt), .o_drop_filt_cnt(filtCnt), .o_drop_ovf_cnt(ovfCnt),
    .o_drop_dec_cnt(decCnt)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts and reports
  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Random beat contents with the filter fields placed at beat0/beat1
  task automatic makeBeat(input int b, input logic [7:0] proto, input logic [15:0] port);
    for (int w = 0; w < DW / 32; w++) sTdata[w*32 +: 32] = $urandom;
    for (int w = 0; w < UW / 32; w++) sTuser[w*32 +: 32] = $urandom;
    sTkeep = $urandom;
    if (b == 0) sTdata[191:184] = proto;
    if (b == 1) sTdata[47:32] = port;
  endtask

  // Drive one whole packet; queue its beats when it is expected on a channel
  task automatic applyStimulus(input int nBeats, input logic [7:0] proto,
                               input logic [15:0] port, input bit pushExp,
                               input int chan);
    expBeat_t e;
    for (int b = 0; b < nBeats; b++) begin
      makeBeat(b, proto, port);
      sTvalid = 1'b1;
      sTlast  = (b == nBeats - 1);
      if (pushExp) begin
        e.chan = chan;
        e.data = sTdata;
        e.keep = sTkeep;
        e.user = sTuser;
        e.last = sTlast;
        expQ.push_back(e);
      end
      @(posedge clk); #1;
    end
    sTvalid = 1'b0;
    sTlast  = 1'b0;
  endtask

  task automatic sendDecision(input logic [SW-1:0] port, input logic drop);
    decValid = 1'b1;
    decPort  = port;
    decDrop  = drop;
    @(posedge clk); #1;
    decValid = 1'b0;
  endtask

  task automatic waitDrain(input string tag);
    int cyc = 0;
    while ((expQ.size() != 0 || mTvalid != '0) && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput({tag, " drain within budget"}, cyc < 2000, 1'b1);
    repeat (3) begin
      @(posedge clk); #1;
    end
  endtask

  // Backpressure pattern on channel 1
  initial begin
    bpPattern = 4'b1001;
    bpIdx = 0;
    bpBit = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bpEnable) begin
        bpBit = bpPattern[3 - bpIdx];
        bpIdx = (bpIdx + 1) % 4;
      end
    end
  end

  // Output monitor: scoreboard pop on handshake, hold check while stalled
  initial begin
    stallPending = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stallPending = 1'b0;
      end else begin
        if (stallPending) begin
          checkOutput("stall hold valid", mTvalid, prevValid);
          checkOutput("stall hold data", mTdata[prevChan*DW +: DW], prevData);
        end
        stallPending = 1'b0;
        for (int k = 0; k < NP; k++) begin
          if (mTvalid[k]) begin
            if (mTready[k]) begin
              if (expQ.size() == 0) begin
                checkOutput("unexpected beat valid", mTvalid, '0);
              end else begin
                popped = expQ.pop_front();
                checkOutput("beat channel", k, popped.chan);
                checkOutput("beat data", mTdata[k*DW +: DW], popped.data);
                checkOutput("beat keep", mTkeep[k*KW +: KW], popped.keep);
                checkOutput("beat user", mTuser[k*UW +: UW], popped.user);
                checkOutput("beat last", mTlast[k], popped.last);
              end
            end else begin
              stallPending = 1'b1;
              prevChan     = k;
              prevData     = mTdata[k*DW +: DW];
              prevValid    = mTvalid;
            end
          end
        end
      end
    end
  end

  // Watchdog
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat;
    rst       = 1'b1;
    sTdata    = '0;
    sTkeep    = '0;
    sTuser    = '0;
    sTvalid   = 1'b0;
    sTlast    = 1'b0;
    decValid  = 1'b0;
    decPort   = '0;
    decDrop   = 1'b0;
    readyBase = '1;
    bpEnable  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset s_axis_tready", sTready, 1'b0);
    checkOutput("reset o_dec_ready", decReady, 1'b1);
    checkOutput("reset m_axis_tvalid", mTvalid, '0);
    checkOutput("reset tdata zero", mTdata != '0, 1'b0);
    checkOutput("reset fwd count", fwdCnt, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("tready after reset", sTready, 1'b1);

    // Filter pass, latency from decision
    $display("[TB] filter pass");
    applyStimulus(4, 8'h11, 16'd4791, 1'b1, 2);
    sendDecision(3'd2, 1'b0);
    lat = 0;
    while (lat < 10) begin
      @(posedge clk); #1;
      lat++;
      if (mTvalid[2]) break;
    end
    checkOutput("first beat latency", lat, 2);
    waitDrain("filter pass");
    checkOutput("fwd count after pass", fwdCnt, 1);

    // Filter rejects: port mismatch, single beat, protocol mismatch
    $display("[TB] filter reject");
    applyStimulus(4, 8'h11, 16'd80, 1'b0, 0);
    applyStimulus(3, 8'h11, 16'd4791, 1'b1, 0);
    sendDecision(3'd0, 1'b0);
    waitDrain("filter reject");
    checkOutput("filt count port", filtCnt, 1);
    checkOutput("fwd count after reject", fwdCnt, 2);
    applyStimulus(1, 8'h11, 16'd4791, 1'b0, 0);
    applyStimulus(3, 8'h06, 16'd4791, 1'b0, 0);
    applyStimulus(2, 8'h11, 16'd4791, 1'b1, 3);
    sendDecision(3'd3, 1'b0);
    waitDrain("reject recovery");
    checkOutput("filt count total", filtCnt, 3);
    checkOutput("fwd count after recovery", fwdCnt, 3);

    // Backpressure on channel 1
    $display("[TB] backpressure");
    bpIdx    = 0;
    bpEnable = 1'b1;
    applyStimulus(6, 8'h11, 16'd4791, 1'b1, 1);
    sendDecision(3'd1, 1'b0);
    waitDrain("backpressure");
    bpEnable = 1'b0;
    checkOutput("fwd count after bp", fwdCnt, 4);

    // Drop decision and out-of-range port
    $display("[TB] drop and invalid port");
    applyStimulus(3, 8'h11, 16'd4791, 1'b0, 0);
    applyStimulus(2, 8'h11, 16'd4791, 1'b0, 0);
    sendDecision(3'd0, 1'b1);
    sendDecision(3'd7, 1'b0);
    repeat (30) @(posedge clk);
    #1;
    checkOutput("dec drop count", decCnt, 2);
    checkOutput("fwd count after drops", fwdCnt, 4);
    checkOutput("no output after drops", mTvalid, '0);

    // Overflow: oversize packet rolled back, next one intact
    $display("[TB] overflow");
    applyStimulus(600, 8'h11, 16'd4791, 1'b0, 0);
    applyStimulus(3, 8'h11, 16'd4791, 1'b1, 3);
    sendDecision(3'd3, 1'b0);
    waitDrain("overflow");
    checkOutput("ovf count", ovfCnt, 1);
    checkOutput("fwd count after ovf", fwdCnt, 5);
    checkOutput("filt count unchanged", filtCnt, 3);

    // Decision queue full
    $display("[TB] decision queue full");
    for (int i = 0; i < 16; i++) begin
      checkOutput("dec ready before full", decReady, 1'b1);
      sendDecision(3'd0, 1'b1);
    end
    checkOutput("dec ready at full", decReady, 1'b0);
    sendDecision(3'd2, 1'b0);
    checkOutput("dec ready after extra", decReady, 1'b0);

    // Asynchronous reset mid-packet
    $display("[TB] reset mid-packet");
    for (int b = 0; b < 3; b++) begin
      makeBeat(b, 8'h11, 16'd4791);
      sTvalid = 1'b1;
      sTlast  = 1'b0;
      @(posedge clk); #1;
    end
    #2;
    rst = 1'b1;
    #1;
    sTvalid = 1'b0;
    checkOutput("mid reset tvalid", mTvalid, '0);
    checkOutput("mid reset tready", sTready, 1'b0);
    checkOutput("mid reset dec ready", decReady, 1'b1);
    checkOutput("mid reset fwd count", fwdCnt, 0);
    checkOutput("mid reset filt count", filtCnt, 0);
    checkOutput("mid reset ovf count", ovfCnt, 0);
    checkOutput("mid reset dec count", decCnt, 0);
    expQ.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(4, 8'h11, 16'd4791, 1'b1, 2);
    sendDecision(3'd2, 1'b0);
    waitDrain("after reset");
    checkOutput("fwd count after reset", fwdCnt, 1);
    checkOutput("dec count after reset", decCnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
